// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B with valid/ready streams and end-of-frame borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_last,
  input  logic a,
  input  logic b,
  output logic d,
  output logic d_valid,
  input  logic out_ready,
  output logic d_last,
  output logic borrow,
  output logic len_err
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_br, w_br_nxt;
  logic          w_acc, w_d, w_bout, w_emit, w_last, w_lerr;

  assign in_ready = (r_state == DRAIN) || !d_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_d      = a ^ b ^ r_br;
  assign w_bout   = (~a & b) | (~(a ^ b) & r_br);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_br    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_br    <= w_br_nxt;
    end
  end

  // Any frame end (normal or forced) clears cnt and br so the next frame starts clean.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_br_nxt    = r_br;
    w_emit      = 1'b0;
    w_last      = 1'b0;
    w_lerr      = 1'b0;
    case (r_state)
      IDLE: if (w_acc) begin
        w_emit = 1'b1;
        if (in_last) begin
          w_last   = 1'b1;
          w_br_nxt = 1'b0;
        end else if (WIDTH == 1) begin
          w_last      = 1'b1;
          w_lerr      = 1'b1;
          w_br_nxt    = 1'b0;
          w_state_nxt = DRAIN;
        end else begin
          w_cnt_nxt   = CW'(1);
          w_br_nxt    = w_bout;
          w_state_nxt = RUN;
        end
      end
      RUN: if (w_acc) begin
        w_emit = 1'b1;
        if (in_last) begin
          w_last      = 1'b1;
          w_cnt_nxt   = '0;
          w_br_nxt    = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_lerr      = 1'b1;
          w_cnt_nxt   = '0;
          w_br_nxt    = 1'b0;
          w_state_nxt = DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_br_nxt  = w_bout;
        end
      end
      DRAIN: if (w_acc && in_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result register: loads on an emitting beat, clears when taken with nothing new behind it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d       <= 1'b0;
      d_valid <= 1'b0;
      d_last  <= 1'b0;
      borrow  <= 1'b0;
      len_err <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (w_emit) begin
      d       <= w_d;
      d_valid <= 1'b1;
      d_last  <= w_last;
      borrow  <= w_last & w_bout;
      len_err <= w_lerr;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= w_last & (a != b) & (w_d != a);
`endif
    end else if (out_ready) begin
      d       <= 1'b0;
      d_valid <= 1'b0;
      d_last  <= 1'b0;
      borrow  <= 1'b0;
      len_err <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): frame-level arithmetic model feeds an expected-beat queue.
module tb_serial_subtractor;
  localparam int WIDTH = 4;

  typedef struct {
    logic d;
    logic last;
    logic brw;
    logic lerr;
    logic ovf;
  } exp_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, a = 1'b0, b = 1'b0, out_ready = 1'b1;
  wire  in_ready, d, d_valid, d_last, borrow, len_err;
`ifdef SERIAL_SUB_OVF_EN
  wire  ovf;
`else
  wire  ovf = 1'b0;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .a(a), .b(b), .d(d), .d_valid(d_valid), .out_ready(out_ready), .d_last(d_last),
    .borrow(borrow), .len_err(len_err)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int   vectors = 0, errors = 0;
  exp_t q[$];
  bit   mon_en = 1'b1, gap_en = 1'b0, hv = 1'b0;
  int   rdy_mode = 0;
  logic [4:0] hold_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-frame integer arithmetic, truncated to WIDTH bits for overlong frames.
  task automatic push_frame(input int n, input int av, input int bv);
    int m, am, bm, diff, sa, sb, sd, lo, hi;
    bit lerr, brw, ov;
    exp_t e;
    m    = (n > WIDTH) ? WIDTH : n;
    lerr = (n > WIDTH);
    am   = av % (1 << m);
    bm   = bv % (1 << m);
    diff = (am - bm + (1 << m)) % (1 << m);
    brw  = (am < bm);
    sa   = (am >= (1 << (m - 1))) ? am - (1 << m) : am;
    sb   = (bm >= (1 << (m - 1))) ? bm - (1 << m) : bm;
    sd   = sa - sb;
    lo   = -(1 << (m - 1));
    hi   = (1 << (m - 1)) - 1;
    ov   = (sd < lo) || (sd > hi);
    for (int i = 0; i < m; i++) begin
      e.d    = diff[i];
      e.last = (i == m - 1);
      e.brw  = e.last ? brw : 1'b0;
      e.lerr = e.last ? lerr : 1'b0;
      e.ovf  = e.last ? ov : 1'b0;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rstn) begin
      if (d_valid) begin
        if (hv) chk("hold_stable", {d, d_last, borrow, len_err, ovf}, hold_val);
        if (out_ready) begin
          hv = 1'b0;
          if (q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_beat: got d=%0b last=%0b expected no beat", d, d_last);
          end else begin
            e = q.pop_front();
            chk("d", d, e.d);
            chk("d_last", d_last, e.last);
            chk("borrow", borrow, e.brw);
            chk("len_err", len_err, e.lerr);
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", ovf, e.ovf);
`endif
          end
        end else begin
          hv = 1'b1;
          hold_val = {d, d_last, borrow, len_err, ovf};
        end
      end else begin
        hv = 1'b0;
        chk("idle_borrow", borrow, 1'b0);
        chk("idle_len_err", len_err, 1'b0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
  task automatic send_beat(input logic ab, input logic bb, input logic lb);
    bit acc = 1'b0;
    int t = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1; a = ab; b = bb; in_last = lb;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (++t > 200) begin
        vectors++; errors++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] av, input logic [7:0] bv);
    push_frame(n, int'(av), int'(bv));
    for (int i = 0; i < n; i++) send_beat(av[i], bv[i], i == n - 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 || d_valid) begin
      @(posedge clk); #1;
      if (++t > 300) begin
        vectors++; errors++;
        $display("FAIL drain_timeout: got %0d beats outstanding expected 0", q.size());
        q.delete();
        break;
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_outs", {d, d_valid, d_last, borrow, len_err, ovf}, 6'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;

    send_frame(4, 8'b0101, 8'b0011); wait_drain();
    send_frame(4, 8'b0011, 8'b0101); wait_drain();
    send_frame(4, 8'b0111, 8'b1000); wait_drain();
    send_frame(6, 8'b101101, 8'b010011);
    send_frame(4, 8'b0001, 8'b0001); wait_drain();
    send_frame(1, 8'b0, 8'b1); send_frame(1, 8'b1, 8'b0); wait_drain();

    // Backpressure: stall after the second beat for three cycles.
    fork send_frame(4, 8'b1010, 8'b0110); join_none
    for (int t = 0; t < 20 && !d_valid; t++) @(negedge clk);
    rdy_mode = 2;
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    rdy_mode = 0;
    wait fork;
    wait_drain();

    // Random frames, random gaps and random backpressure.
    gap_en = 1'b1; rdy_mode = 1;
    for (int f = 0; f < 40; f++)
      send_frame($urandom_range(1, 6), 8'($urandom), 8'($urandom));
    rdy_mode = 0; gap_en = 1'b0;
    wait_drain();

    // Reset mid-frame.
    mon_en = 1'b0;
    send_beat(1'b1, 1'b0, 1'b0);
    send_beat(1'b0, 1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_outs", {d, d_valid, d_last, borrow, len_err, ovf}, 6'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1; rstn = 1'b1;
    q.delete(); hv = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;
    send_frame(1, 8'b1, 8'b1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
